hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_src_match.sv | 49 ++++
 rtl/hazard_scoreboard.sv | 98 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default sizes for the hazard scoreboard slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF = 3;
    localparam int DEPTH_DEF      = 3;
    // Entries store specifiers at a fixed width so one struct type serves
    // every REG_ADDR_W up to this limit; narrower specifiers are zero-extended.
    localparam int REG_ADDR_W_MAX = 8;
    localparam int SEL_W          = 3;

    typedef logic [REG_ADDR_W_MAX-1:0] regAddr_t;

    typedef struct packed {
        logic     valid;
        regAddr_t rd;
        logic     isLoad;
    } entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// Matches one decode source against all in-flight entries, youngest wins.
// Latency: purely combinational.
// Backpressure: none; the parent turns loadUse/anyMatch into a stall.
//
// Ports: srcUsed/idValid/src describe the source; entries is the in-flight
// window (index 0 = youngest); anyMatch = any hit, sel = 1 + youngest hit
// index (0 = none), loadUse = youngest hit is a load sitting in entry 0.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  srcUsed,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] src,
    input  entry_t [DEPTH-1:0]    entries,
    output logic                  anyMatch,
    output logic                  loadUse,
    output logic [SEL_W-1:0]      sel
);

    regAddr_t         srcWide;
    logic [DEPTH-1:0] hit;
    logic             selIsLoad;

    assign srcWide = regAddr_t'(src);

    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        assign hit[i] = srcUsed & idValid & entries[i].valid & (entries[i].rd == srcWide);
    end

    // Walk oldest to youngest so the last assignment is the youngest hit.
    always_comb begin
        sel       = '0;
        selIsLoad = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel       = SEL_W'(i + 1);
                selIsLoad = entries[i].isLoad;
            end
        end
    end

    assign anyMatch = |hit;
    // Only a load still in EX cannot be forwarded in time.
    assign loadUse  = hit[0] & selIsLoad;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight destination registers and raises stall / forward selects.
// Latency: stall and fwd selects are combinational from decode and entry state.
// Backpressure: stall holds fetch/decode and injects a bubble into entry 0.
//
// Ports: clk, rst (async, active high); id_* describe the decode instruction;
// flush kills the decode instruction; stall, fwd_rs_sel, fwd_rt_sel
// (0 = regfile, k = entry k-1) and saturating stall_cnt are outputs.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int FWD_EN     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic [SEL_W-1:0]      fwd_rs_sel,
    output logic [SEL_W-1:0]      fwd_rt_sel,
    output logic [15:0]           stall_cnt
);

    entry_t [DEPTH-1:0] entries;
    entry_t             newEntry;

    logic               rsAny, rtAny;
    logic               rsLoadUse, rtLoadUse;
    logic [SEL_W-1:0]   rsSel, rtSel;
    logic               stallRaw;

    hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) uRsMatch (
        .srcUsed  (id_rs_used),
        .idValid  (id_valid),
        .src      (id_rs),
        .entries  (entries),
        .anyMatch (rsAny),
        .loadUse  (rsLoadUse),
        .sel      (rsSel)
    );

    hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH)) uRtMatch (
        .srcUsed  (id_rt_used),
        .idValid  (id_valid),
        .src      (id_rt),
        .entries  (entries),
        .anyMatch (rtAny),
        .loadUse  (rtLoadUse),
        .sel      (rtSel)
    );

    // Without forwarding every pending producer blocks; with forwarding only
    // a load-use pair does.
    assign stallRaw = (FWD_EN != 0) ? (rsLoadUse | rtLoadUse) : (rsAny | rtAny);

    // flush is used only as a mask: the instruction it kills must not stall
    // or consume a forward.
    assign stall      = stallRaw & ~flush;
    assign fwd_rs_sel = ((FWD_EN != 0) && !flush) ? rsSel : '0;
    assign fwd_rt_sel = ((FWD_EN != 0) && !flush) ? rtSel : '0;

    always_comb begin
        newEntry        = '0;
        newEntry.valid  = id_valid & id_wr_en;
        newEntry.rd     = regAddr_t'(id_rd);
        newEntry.isLoad = id_is_load;
    end

    // Older entries always advance; only the decode slot is bubbled on
    // stall or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= '0;
        end else begin
            entries[0] <= (stall | flush) ? entry_t'('0) : newEntry;
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
